// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Serial transmitter. Frames a parallel word as a start bit,
//               DATA_W data bits (LSB first), an optional even-parity bit
//               and a stop bit. Takes bytes over a valid/ready handshake
//               and times each bit with an internal clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] c_bit_one  = BIT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_accept;
    logic              w_bit_end;
    logic              w_tx_nxt;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // ready is only ever high in IDLE, so this is the acceptance strobe
    assign w_accept  = valid & r_ready;
    assign w_bit_end = (r_div == c_div_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every non-idle state lasts one full bit period
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_bit_last)) begin
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the
    // next state so tx changes exactly on the bit boundary without glitches
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = data_in;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_nxt = r_shift >> 1;
        end

        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = r_parity;
            default:  w_tx_nxt = 1'b1;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (r_state == S_STOP) && w_bit_end;
    end

    // Datapath: bit divider, data-bit counter, shift register and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_div_one;
            end

            if (w_accept) begin
                r_bit_cnt <= '0;
                r_parity  <= ^data_in;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + c_bit_one;
            end

            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx. Three instances cover the
//               base setup, even parity and one clock per bit. Stimulus
//               pushes the expected frame on acceptance; a line monitor per
//               instance decodes tx and pops/compares each finished frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din [3];
    logic [2:0] valid_v;
    logic [2:0] ready_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc;
    int done_cnt   [3] = '{0, 0, 0};
    int done_cyc   [3] = '{0, 0, 0};
    int frames     [3] = '{0, 0, 0};
    int start_prev [3] = '{0, 0, 0};
    int start_last [3] = '{0, 0, 0};

    // expected {parity, data} per instance
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            uart_tx #(
                .DATA_W      (8),
                .CLKS_PER_BIT((g == 2) ? 1 : 4),
                .PARITY_EN   ((g == 1) ? 1 : 0)
            ) u_dut (
                .clk    (clk),
                .rst    (rst),
                .data_in(din[g]),
                .valid  (valid_v[g]),
                .ready  (ready_v[g]),
                .tx     (tx_v[g]),
                .busy   (busy_v[g]),
                .done   (done_v[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // done pulse counter and timestamp per instance
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] === 1'b1) begin
                    done_cnt[i] = done_cnt[i] + 1;
                    done_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [8:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int idx, output logic [8:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        case (idx)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Line monitor: decodes one frame from tx, checks every bit is held for
    // cpb cycles with busy high, then checks done and compares to scoreboard
    task automatic monitor(input int idx, input int cpb, input bit par_en);
        logic        prev;
        logic [15:0] bits;
        bit          steady;
        bit          abort;
        bit          ok;
        int          nbits;
        logic [8:0]  e;
        logic [12:0] act;
        logic [12:0] exp_w;
        prev  = 1'b1;
        nbits = 10 + int'(par_en);
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev = 1'b1;
                continue;
            end
            if (!(prev === 1'b1 && tx_v[idx] === 1'b0)) begin
                prev = tx_v[idx];
                continue;
            end
            start_prev[idx] = start_last[idx];
            start_last[idx] = cyc;
            bits   = '0;
            steady = 1'b1;
            abort  = 1'b0;
            for (int b = 0; b < nbits && !abort; b++) begin
                for (int k = 0; k < cpb && !abort; k++) begin
                    if (b != 0 || k != 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        abort = 1'b1;
                    end else begin
                        if (k == 0) bits[b] = tx_v[idx];
                        else if (tx_v[idx] !== bits[b]) steady = 1'b0;
                        if (busy_v[idx] !== 1'b1) steady = 1'b0;
                    end
                end
            end
            if (abort) begin
                prev = 1'b1;
                continue;
            end
            @(negedge clk);
            act = {bits[0], bits[8:1], (par_en ? bits[9] : 1'b0), bits[nbits-1],
                   steady, done_v[idx]};
            frames[idx] = frames[idx] + 1;
            pop_exp(idx, e, ok);
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame%0d: got 0x%0h expected no frame", idx, act);
            end else begin
                exp_w = {1'b0, e[7:0], (par_en ? e[8] : 1'b0), 3'b111};
                chk($sformatf("frame%0d", idx), 32'(act), 32'(exp_w));
            end
            prev = tx_v[idx];
        end
    endtask

    initial monitor(0, 4, 1'b0);
    initial monitor(1, 4, 1'b1);
    initial monitor(2, 1, 1'b0);

    // Present a word and wait for acceptance; valid is left high afterwards
    task automatic send(input int idx, input logic [7:0] d, input logic p, input bit expect_it);
        int n;
        n = 0;
        din[idx]     = d;
        valid_v[idx] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ready_v[idx] === 1'b1) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (expect_it) push_exp(idx, {p, d});
        end
    endtask

    task automatic wait_done(input int idx, input int target);
        int n;
        n = 0;
        while (done_cnt[idx] < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("done_count%0d", idx), 32'(done_cnt[idx]), 32'(target));
    endtask

    initial begin
        rst     = 1'b1;
        valid_v = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 8'h3C;

        // reset held with valid high: idle outputs, nothing accepted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_tx",    32'(tx_v),    32'h7);
            chk("rst_ready", 32'(ready_v), 32'h7);
            chk("rst_busy",  32'(busy_v),  32'h0);
            chk("rst_done",  32'(done_v),  32'h0);
        end
        rst     = 1'b0;
        valid_v = 3'b000;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(ready_v), 32'h7);

        // single frame 0xA5, 4 clocks per bit, no parity
        send(0, 8'hA5, 1'b0, 1'b1);
        valid_v[0] = 1'b0;
        wait_done(0, 1);
        chk("latency0", 32'(done_cyc[0] - acc_cyc), 32'd40);

        // parity: 0x01 -> parity 1 (44-cycle frame), 0xA5 -> parity 0
        send(1, 8'h01, 1'b1, 1'b1);
        valid_v[1] = 1'b0;
        wait_done(1, 1);
        chk("latency1", 32'(done_cyc[1] - acc_cyc), 32'd44);
        send(1, 8'hA5, 1'b0, 1'b1);
        valid_v[1] = 1'b0;
        wait_done(1, 2);

        // back-to-back with valid held high
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        valid_v[0] = 1'b0;
        wait_done(0, 3);
        chk("b2b_pitch", 32'(start_last[0] - start_prev[0]), 32'd41);

        // reset during the third data bit abandons the frame
        send(0, 8'hA5, 1'b0, 1'b0);
        valid_v[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx",    32'(tx_v[0]),    32'h1);
        chk("midrst_ready", 32'(ready_v[0]), 32'h1);
        chk("midrst_busy",  32'(busy_v[0]),  32'h0);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt[0]), 32'd3);
        send(0, 8'h5A, 1'b0, 1'b1);
        valid_v[0] = 1'b0;
        wait_done(0, 4);

        // one clock per bit; data_in changes while busy are ignored
        send(2, 8'h81, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        din[2] = 8'h7E;
        repeat (3) @(posedge clk);
        #1;
        valid_v[2] = 1'b0;
        wait_done(2, 1);
        chk("latency2", 32'(done_cyc[2] - acc_cyc), 32'd10);
        repeat (20) @(posedge clk);
        #1;

        chk("frames0", 32'(frames[0]), 32'd4);
        chk("frames1", 32'(frames[1]), 32'd2);
        chk("frames2", 32'(frames[2]), 32'd1);
        chk("done2_total", 32'(done_cnt[2]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("queue_left%0d", i), 32'(q_size(i)), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that frames a parallel byte as start bit, data bits (LSB first), optional even parity bit and stop bit. It drives the bit line sampled by the team's flip-flop based serial capture logic, so it is the sending end of that serial link. A valid/ready handshake on the parallel side lets upstream logic push bytes back-to-back. Bit timing comes from an internal clock-divider counter.

Parameters:
DATA_W, 8, number of data bits per frame (1..16).
CLKS_PER_BIT, 4, clk cycles per serial bit (>=1); counter width is $clog2(CLKS_PER_BIT)+1.
PARITY_EN, 0, 1 = insert even-parity bit after the data bits; 0 = no parity bit.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  DATA_W  byte to send; sampled only on acceptance.
valid  input  1  upstream has data_in ready.
ready  output  1  block can accept a byte this cycle.
tx  output  1  serial line; idle/stop level is 1.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: tx=1, ready=1, busy=0, done=0, state=IDLE, bit counter=0, divider=0, shift register=0.
- Reset mid-frame: at the next rising edge with rst=1, the frame is abandoned. tx returns to 1 and no done pulse is issued. rst overrides every other input.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- Acceptance: a byte is accepted at a rising edge where valid=1 and ready=1. On that edge:
  - data_in is latched into the shift register.
  - Parity (XOR of data_in) is latched.
  - state goes to START; tx<=0, ready<=0, busy<=1, divider<=0.
- data_in/valid changes while ready=0 are ignored. valid may stay high with no effect.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles. The divider counts 0..CLKS_PER_BIT-1, and the state advances when it reaches CLKS_PER_BIT-1.
- START: tx=0, then goes to DATA.
- DATA: tx=shift[0]. At the end of each bit the register shifts right and the bit counter increments. After DATA_W bits it goes to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx=even parity bit (1 if data has an odd number of ones), then goes to STOP.
- STOP: tx=1. At the end of the bit: state=IDLE, ready<=1, busy<=0, done<=1 for exactly one cycle.
- Latency:
  - tx leaves idle 1 cycle after the accepting edge.
  - A frame occupies (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
  - done rises with ready in the same cycle.
- Throughput: ready is high for at least one cycle between frames. With valid held high, the next byte is accepted at the first edge with ready=1. Frame pitch is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT+1 cycles, and tx stays 1 during the gap cycle.
- CLKS_PER_BIT=1: every state lasts one cycle and the divider is always 0.
- done and valid in the same cycle: the byte is accepted, done still pulses, and ready drops on the following edge.

Test Plan:
- Reset: hold rst=1 for 3 cycles with valid=1, data_in=0x3C -> tx=1, ready=1, busy=0, done=0 throughout; nothing accepted.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0: send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses 40 cycles after the accepting edge; busy high for those 40 cycles.
- Parity, PARITY_EN=1: send 0x01 -> parity bit 1 follows data and frame is 44 cycles. Send 0xA5 -> parity bit 0.
- Back-to-back: valid held high with 0x00 then 0xFF -> second start bit begins 41 cycles after the first. tx is 1 in exactly one gap cycle, and done pulses once per frame.
- Mid-frame reset: assert rst during the 3rd data bit of 0xA5 -> tx=1 and ready=1 at the next edge, no done pulse. A fresh 0x5A sent afterwards transmits correctly.
- Ignore while busy, CLKS_PER_BIT=1: send 0x81, change data_in to 0x7E mid-frame -> tx shows 0,1,0,0,0,0,0,0,1,1 at one cycle per bit; 0x7E is never transmitted unless it is still presented when ready returns.
